// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with a 2-entry
// load-return FIFO, with head ageing, a stall request and a pending-write mask.
module rf_write_arbiter #(
   parameter int unsigned MAXWAIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WB_REQ,
   input  logic [3:0]  WB_C,
   input  logic [31:0] WB_D,
   input  logic        LD_VALID,
   input  logic [3:0]  LD_C,
   input  logic [31:0] LD_D,
   output logic        LD_READY,
   input  logic        PC_EN,
   output logic        RFLd,
   output logic [3:0]  C,
   output logic [31:0] PW,
   output logic        HZPCld,
   output logic        STALL,
   output logic [15:0] BUSY_MASK,
   output logic        ERR
);

   localparam int unsigned RW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 3;
   localparam int unsigned NREG  = 16;
   localparam int unsigned DEPTH = 2;
   localparam logic [AW-1:0] AGE_MAX = '1;

   typedef struct packed {
      logic [RW-1:0] c;
      logic [DW-1:0] d;
   } wr_t;

   wr_t             r_fifo [DEPTH];
   logic [DEPTH-1:0] r_val;
   logic [AW-1:0]   r_age;
   logic            r_ld_ready;
   logic            r_rfld;
   logic [RW-1:0]   r_c;
   logic [DW-1:0]   r_pw;
   logic            r_stall;
   logic [NREG-1:0] r_busy;
   logic            r_err;

   wr_t             w_fifo_n [DEPTH];
   logic [DEPTH-1:0] w_val_n;
   logic [AW-1:0]   w_age_n;
   logic            w_pop;
   logic            w_push;
   logic            w_gnt;
   logic [RW-1:0]   w_c_n;
   logic [DW-1:0]   w_pw_n;
   logic [NREG-1:0] w_busy_n;

   // Grant, FIFO shift/fill, head ageing and next pending-write mask.
   always_comb begin
      w_fifo_n = r_fifo;
      w_val_n  = r_val;
      w_age_n  = r_age;
      w_busy_n = '0;
      w_pop    = ~WB_REQ & r_val[0];
      w_push   = LD_VALID & r_ld_ready;
      w_gnt    = WB_REQ | r_val[0];
      w_c_n    = r_c;
      w_pw_n   = r_pw;

      if (WB_REQ) begin
         w_c_n  = WB_C;
         w_pw_n = WB_D;
      end else if (r_val[0]) begin
         w_c_n  = r_fifo[0].c;
         w_pw_n = r_fifo[0].d;
      end

      if (w_pop) begin
         w_fifo_n[0] = r_fifo[1];
         w_val_n[0]  = r_val[1];
         w_val_n[1]  = 1'b0;
      end
      // New entry lands in the first free slot after any pop has shifted.
      if (w_push) begin
         if (!w_val_n[0]) begin
            w_fifo_n[0] = '{c: LD_C, d: LD_D};
            w_val_n[0]  = 1'b1;
         end else begin
            w_fifo_n[1] = '{c: LD_C, d: LD_D};
            w_val_n[1]  = 1'b1;
         end
      end

      if (w_pop || !r_val[0])
         w_age_n = '0;
      else if (r_age != AGE_MAX)
         w_age_n = r_age + AW'(1);

      for (int i = 0; i < int'(DEPTH); i++)
         if (w_val_n[i]) w_busy_n[w_fifo_n[i].c] = 1'b1;
      if (w_gnt) w_busy_n[w_c_n] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(DEPTH); i++) r_fifo[i] <= '0;
         r_val      <= '0;
         r_age      <= '0;
         r_ld_ready <= 1'b0;
         r_rfld     <= 1'b0;
         r_c        <= '0;
         r_pw       <= '0;
         r_stall    <= 1'b0;
         r_busy     <= '0;
         r_err      <= 1'b0;
      end else begin
         r_fifo     <= w_fifo_n;
         r_val      <= w_val_n;
         r_age      <= w_age_n;
         r_ld_ready <= ~w_val_n[DEPTH-1];
         r_rfld     <= w_gnt;
         r_c        <= w_c_n;
         r_pw       <= w_pw_n;
         r_stall    <= (w_age_n == AW'(MAXWAIT));
         r_busy     <= w_busy_n;
         r_err      <= r_err | (WB_REQ & r_stall);
      end
   end

   assign LD_READY  = r_ld_ready;
   assign RFLd      = r_rfld;
   assign C         = r_c;
   assign PW        = r_pw;
   assign STALL     = r_stall;
   assign BUSY_MASK = r_busy;
   assign ERR       = r_err;
   assign HZPCld    = PC_EN | (r_rfld & (r_c == 4'hF));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued by the
// stimulus and matched by a negedge monitor whenever RFLd is high.
module tb_rf_write_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        WB_REQ = 1'b0;
   logic [3:0]  WB_C = '0;
   logic [31:0] WB_D = '0;
   logic        LD_VALID = 1'b0;
   logic [3:0]  LD_C = '0;
   logic [31:0] LD_D = '0;
   logic        PC_EN = 1'b0;
   logic        LD_READY, RFLd, HZPCld, STALL, ERR;
   logic [3:0]  C;
   logic [31:0] PW;
   logic [15:0] BUSY_MASK;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  c;
      logic [31:0] d;
   } exp_t;
   exp_t sb [$];

   rf_write_arbiter #(.MAXWAIT(4)) dut (
      .CLK(CLK), .RST(RST), .WB_REQ(WB_REQ), .WB_C(WB_C), .WB_D(WB_D),
      .LD_VALID(LD_VALID), .LD_C(LD_C), .LD_D(LD_D), .LD_READY(LD_READY),
      .PC_EN(PC_EN), .RFLd(RFLd), .C(C), .PW(PW), .HZPCld(HZPCld),
      .STALL(STALL), .BUSY_MASK(BUSY_MASK), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drv(input logic wb, input logic [3:0] wc, input logic [31:0] wd,
                      input logic lv, input logic [3:0] lc, input logic [31:0] ldd);
      WB_REQ = wb; WB_C = wc; WB_D = wd;
      LD_VALID = lv; LD_C = lc; LD_D = ldd;
   endtask

   task automatic expect_wr(input logic [3:0] c, input logic [31:0] d);
      exp_t e;
      e.c = c;
      e.d = d;
      sb.push_back(e);
   endtask

   // Monitor: every observed write must match the oldest expected one.
   always @(negedge CLK) begin
      if (RFLd === 1'b1) begin
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_write: got C=%0d PW=%0d expected no write", C, PW);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_c", 32'(C), 32'(e.c));
            chk("wr_pw", PW, e.d);
         end
      end
   end

   initial begin
      // Reset state
      #3;
      chk("rst_rfld", 32'(RFLd), 0);
      chk("rst_ld_ready", 32'(LD_READY), 0);
      chk("rst_busy", 32'(BUSY_MASK), 0);
      chk("rst_hzpcld", 32'(HZPCld), 0);
      @(negedge CLK);
      RST = 1'b1;
      tick();
      chk("post_rst_ld_ready", 32'(LD_READY), 1);

      // Single writeback
      drv(1, 4'd3, 32'd90, 0, 0, 0);
      expect_wr(4'd3, 32'd90);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("wb_busy", 32'(BUSY_MASK), 32'h0008);
      tick();
      chk("idle_rfld", 32'(RFLd), 0);
      chk("idle_c_held", 32'(C), 3);

      // Simultaneous WB and load
      drv(1, 4'd2, 32'd11, 1, 4'd5, 32'd73);
      expect_wr(4'd2, 32'd11);
      expect_wr(4'd5, 32'd73);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("both_ld_ready", 32'(LD_READY), 1);
      chk("both_busy", 32'(BUSY_MASK), 32'h0024);
      tick();
      chk("both_ld_ready2", 32'(LD_READY), 1);
      chk("both_busy2", 32'(BUSY_MASK), 32'h0020);
      tick();

      // Starved load raises STALL after MAXWAIT cycles
      for (int i = 0; i < 5; i++) begin
         drv(1, 4'd1, 32'(100 + i), (i == 0), 4'd6, 32'd200);
         expect_wr(4'd1, 32'(100 + i));
         tick();
         chk("stall_age", 32'(STALL), (i == 4) ? 1 : 0);
      end
      drv(0, 0, 0, 0, 0, 0);
      expect_wr(4'd6, 32'd200);
      tick();
      chk("stall_clear", 32'(STALL), 0);
      chk("stall_no_err", 32'(ERR), 0);
      tick();

      // FIFO full back-pressure
      drv(1, 4'd8, 32'd1, 1, 4'd9, 32'd21);
      expect_wr(4'd8, 32'd1);
      tick();
      chk("full_ready_1", 32'(LD_READY), 1);
      drv(1, 4'd8, 32'd2, 1, 4'd10, 32'd22);
      expect_wr(4'd8, 32'd2);
      tick();
      chk("full_ready_0", 32'(LD_READY), 0);
      drv(1, 4'd8, 32'd3, 1, 4'd11, 32'd23);
      expect_wr(4'd8, 32'd3);
      tick();
      chk("full_reject", 32'(LD_READY), 0);
      chk("full_busy", 32'(BUSY_MASK), 32'h0700);
      drv(0, 0, 0, 0, 0, 0);
      expect_wr(4'd9, 32'd21);
      expect_wr(4'd10, 32'd22);
      tick();
      chk("full_ready_back", 32'(LD_READY), 1);
      tick();
      tick();

      // R15 write loads PC
      drv(0, 0, 0, 1, 4'd15, 32'd35);
      expect_wr(4'd15, 32'd35);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("r15_pre", 32'(HZPCld), 0);
      tick();
      chk("r15_write", 32'(HZPCld), 1);
      tick();
      chk("r15_after", 32'(HZPCld), 0);
      PC_EN = 1'b1;
      #1;
      chk("pc_en_pass", 32'(HZPCld), 1);
      PC_EN = 1'b0;

      // WB during STALL sets sticky ERR
      for (int i = 0; i < 6; i++) begin
         drv(1, 4'd1, 32'(400 + i), (i == 0), 4'd7, 32'd300);
         expect_wr(4'd1, 32'(400 + i));
         tick();
      end
      chk("err_set", 32'(ERR), 1);
      chk("err_stall_one_cycle", 32'(STALL), 0);
      drv(0, 0, 0, 0, 0, 0);
      expect_wr(4'd7, 32'd300);
      tick();
      tick();
      chk("err_sticky", 32'(ERR), 1);

      // Reset with two entries queued discards them
      drv(1, 4'd12, 32'd500, 1, 4'd13, 32'd501);
      expect_wr(4'd12, 32'd500);
      tick();
      drv(1, 4'd12, 32'd502, 1, 4'd14, 32'd503);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      #1;
      RST = 1'b0;
      #1;
      chk("mid_rst_rfld", 32'(RFLd), 0);
      chk("mid_rst_pw", PW, 0);
      chk("mid_rst_c", 32'(C), 0);
      chk("mid_rst_err", 32'(ERR), 0);
      chk("mid_rst_busy", 32'(BUSY_MASK), 0);
      chk("mid_rst_ready", 32'(LD_READY), 0);
      chk("mid_rst_stall", 32'(STALL), 0);
      tick();
      @(negedge CLK);
      RST = 1'b1;
      tick();
      chk("rerst_ready", 32'(LD_READY), 1);
      for (int i = 0; i < 4; i++) tick();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
